mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified instruction/data memory between the multicycle core (fetch and load/store traffic issued by the control unit) and the debug/program loader. Each cycle it grants at most one requester using round-robin priority. A loader lock lets a burst program load run uninterrupted. Read data returns after a fixed memory latency, and the arbiter routes the valid strobe back to the requester that issued the read.

---
 rtl/mem_arbiter_if.sv | 81 ++++++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the unified memory.
// The arbiter takes the slave side; requesters and memory model take the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [STRB_W-1:0] core_wstrb;
    logic              core_gnt;
    logic              core_rvalid;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [STRB_W-1:0] dbg_wstrb;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic              dbg_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              mem_en;
    logic [STRB_W-1:0] mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req,
        input  core_we,
        input  core_addr,
        input  core_wdata,
        input  core_wstrb,
        output core_gnt,
        output core_rvalid,
        input  dbg_req,
        input  dbg_we,
        input  dbg_addr,
        input  dbg_wdata,
        input  dbg_wstrb,
        input  dbg_lock,
        output dbg_gnt,
        output dbg_rvalid,
        output rdata,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req,
        output core_we,
        output core_addr,
        output core_wdata,
        output core_wstrb,
        input  core_gnt,
        input  core_rvalid,
        output dbg_req,
        output dbg_we,
        output dbg_addr,
        output dbg_wdata,
        output dbg_wstrb,
        output dbg_lock,
        input  dbg_gnt,
        input  dbg_rvalid,
        input  rdata,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the unified memory between the core and the loader,
// with a loader burst lock and a fixed-latency read-return owner pipeline.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic         clk,
    input logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    owner_t            last_gnt;
    logic              locked;
    logic              lock_now;
    logic              core_gnt;
    logic              dbg_gnt;
    logic              rd_issue;
    owner_t            rd_owner;

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [STRB_W-1:0] we_sel;

    logic [MEM_LAT-1:0] pipe_valid;
    owner_t             pipe_owner [MEM_LAT];

    // A fresh lock request blocks the core in the same cycle it is taken,
    // and dropping dbg_lock frees the core in the same cycle.
    assign lock_now = bus.dbg_lock & (locked | bus.dbg_req);

    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst_n) begin
            core_gnt = 1'b0;
            dbg_gnt  = 1'b0;
        end else if (lock_now) begin
            dbg_gnt = bus.dbg_req;
        end else if (bus.core_req && bus.dbg_req) begin
            if (last_gnt == OWN_DBG) begin
                core_gnt = 1'b1;
            end else begin
                dbg_gnt = 1'b1;
            end
        end else begin
            core_gnt = bus.core_req;
            dbg_gnt  = bus.dbg_req;
        end
    end

    always_comb begin
        addr_sel  = bus.core_addr;
        wdata_sel = bus.core_wdata;
        we_sel    = '0;
        if (dbg_gnt) begin
            addr_sel  = bus.dbg_addr;
            wdata_sel = bus.dbg_wdata;
            if (bus.dbg_we) begin
                we_sel = bus.dbg_wstrb;
            end
        end else if (core_gnt) begin
            if (bus.core_we) begin
                we_sel = bus.core_wstrb;
            end
        end
    end

    assign rd_issue = (core_gnt & ~bus.core_we) | (dbg_gnt & ~bus.dbg_we);
    assign rd_owner = dbg_gnt ? OWN_DBG : OWN_CORE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= OWN_DBG;
            locked   <= 1'b0;
        end else begin
            if (core_gnt) begin
                last_gnt <= OWN_CORE;
            end else if (dbg_gnt) begin
                last_gnt <= OWN_DBG;
            end
            locked <= bus.dbg_lock & (locked | dbg_gnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_owner[i] <= OWN_CORE;
            end
        end else begin
            pipe_valid[0] <= rd_issue;
            pipe_owner[0] <= rd_owner;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    assign bus.core_gnt    = core_gnt;
    assign bus.dbg_gnt     = dbg_gnt;
    assign bus.core_rvalid = pipe_valid[MEM_LAT-1] &
                             (pipe_owner[MEM_LAT-1] == OWN_CORE);
    assign bus.dbg_rvalid  = pipe_valid[MEM_LAT-1] &
                             (pipe_owner[MEM_LAT-1] == OWN_DBG);
    assign bus.rdata       = bus.mem_rdata;

    assign bus.mem_en    = core_gnt | dbg_gnt;
    assign bus.mem_we    = we_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at read latencies 1, 2 and 3 driven in lockstep;
// read returns are checked against a scoreboard of expected owner/data/cycle.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  core_wstrb, dbg_wstrb;

    logic [2:0]  cgnt, dgnt, men, core_rv, dbg_rv;
    logic [3:0]  mwe [3];
    logic [31:0] maddr [3];
    logic [31:0] mwdata [3];
    logic [31:0] rd [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int          due;
        int          k;
        bit          dbg;
        logic [31:0] data;
    } exp_t;
    exp_t sb [$];

    function automatic logic [31:0] mdata(logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a ^ 32'hA5A5_0000) + 32'h1;
    endfunction

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
        logic [31:0] mp [4];

        assign b.core_req   = core_req;
        assign b.core_we    = core_we;
        assign b.core_addr  = core_addr;
        assign b.core_wdata = core_wdata;
        assign b.core_wstrb = core_wstrb;
        assign b.dbg_req    = dbg_req;
        assign b.dbg_we     = dbg_we;
        assign b.dbg_addr   = dbg_addr;
        assign b.dbg_wdata  = dbg_wdata;
        assign b.dbg_wstrb  = dbg_wstrb;
        assign b.dbg_lock   = dbg_lock;

        // Memory model: read data for the address seen in a cycle appears k+1 cycles later.
        always @(posedge clk) begin
            mp[0] <= mdata(b.mem_addr);
            for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
        end
        assign b.mem_rdata = mp[k];

        assign cgnt[k]    = b.core_gnt;
        assign dgnt[k]    = b.dbg_gnt;
        assign men[k]     = b.mem_en;
        assign core_rv[k] = b.core_rvalid;
        assign dbg_rv[k]  = b.dbg_rvalid;
        assign mwe[k]     = b.mem_we;
        assign maddr[k]   = b.mem_addr;
        assign mwdata[k]  = b.mem_wdata;
        assign rd[k]      = b.rdata;

        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(k + 1)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (b.slave)
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    int idx;
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 3; k++) begin
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].k == k && sb[i].due <= cyc) idx = i;
                end
                chk($sformatf("lat%0d.core_rvalid@%0d", k + 1, cyc), 32'(core_rv[k]),
                    32'(idx >= 0 && !sb[idx].dbg));
                chk($sformatf("lat%0d.dbg_rvalid@%0d", k + 1, cyc), 32'(dbg_rv[k]),
                    32'(idx >= 0 && sb[idx].dbg));
                if (idx >= 0) begin
                    chk($sformatf("lat%0d.rdata@%0d", k + 1, cyc), rd[k], sb[idx].data);
                    chk($sformatf("lat%0d.due@%0d", k + 1, cyc), cyc, sb[idx].due);
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic set_core(bit req, bit we, logic [31:0] a,
                            logic [31:0] wd, logic [3:0] st);
        core_req = req; core_we = we; core_addr = a;
        core_wdata = wd; core_wstrb = st;
    endtask

    task automatic set_dbg(bit req, bit we, logic [31:0] a,
                           logic [31:0] wd, logic [3:0] st, bit lk);
        dbg_req = req; dbg_we = we; dbg_addr = a;
        dbg_wdata = wd; dbg_wstrb = st; dbg_lock = lk;
    endtask

    task automatic step(string tag, bit ecg, bit edg);
        logic [31:0] ea, ew;
        logic [3:0]  ewe;
        bit          erd;
        @(negedge clk);
        ea  = edg ? dbg_addr : core_addr;
        ew  = edg ? dbg_wdata : core_wdata;
        ewe = (ecg && core_we) ? core_wstrb : (edg && dbg_we) ? dbg_wstrb : 4'h0;
        erd = (ecg && !core_we) || (edg && !dbg_we);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.core_gnt%0d", tag, k), 32'(cgnt[k]), 32'(ecg));
            chk($sformatf("%s.dbg_gnt%0d", tag, k), 32'(dgnt[k]), 32'(edg));
        end
        chk({tag, ".mem_en"}, 32'(men[0]), 32'(ecg | edg));
        chk({tag, ".mem_we"}, 32'(mwe[0]), 32'(ewe));
        chk({tag, ".mem_addr"}, maddr[0], ea);
        chk({tag, ".mem_wdata"}, mwdata[0], ew);
        if (erd) begin
            for (int k = 0; k < 3; k++) begin
                sb.push_back('{due: cyc + k + 1, k: k, dbg: edg, data: mdata(ea)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_core(1, 1, 32'h4, 32'h1, 4'hF);
        set_dbg(1, 1, 32'h8, 32'h2, 4'hF, 1);
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        step("reset0", 0, 0);
        step("reset1", 0, 0);
        set_core(0, 0, 32'h4, 32'h0, 4'h0);
        set_dbg(0, 0, 32'h8, 32'h0, 4'h0, 0);
        rst_n = 1'b1;
        step("idle", 0, 0);

        set_core(1, 0, 32'h10, 32'h0, 4'h0);
        set_dbg(1, 0, 32'h20, 32'h0, 4'h0, 0);
        step("cont0", 1, 0);
        step("cont1", 0, 1);
        step("cont2", 1, 0);
        step("cont3", 0, 1);
        set_core(0, 0, 32'h10, 32'h0, 4'h0);
        set_dbg(0, 0, 32'h20, 32'h0, 4'h0, 0);
        repeat (4) step("drain", 0, 0);

        set_core(1, 0, 32'h30, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            set_dbg(1, 1, 32'(i * 4), 32'h100 + 32'(i), 4'hF, 1);
            step($sformatf("lock%0d", i), 0, 1);
        end
        set_dbg(1, 1, 32'h14, 32'h105, 4'hF, 0);
        step("release", 1, 0);
        set_core(0, 0, 32'h30, 32'h0, 4'h0);
        step("post", 0, 1);
        set_dbg(0, 0, 32'h14, 32'h0, 4'h0, 0);
        repeat (4) step("drain", 0, 0);

        set_core(1, 0, 32'h10, 32'h0, 4'h0);
        step("rd", 1, 0);
        set_core(0, 0, 32'h10, 32'h0, 4'h0);
        repeat (4) step("drain", 0, 0);

        set_core(1, 1, 32'h40, 32'h00AB_0000, 4'h4);
        step("bytewr", 1, 0);
        set_core(0, 0, 32'h40, 32'h0, 4'h0);
        repeat (4) step("drain", 0, 0);

        set_core(1, 0, 32'h50, 32'h0, 4'h0);
        step("mix0", 1, 0);
        set_core(0, 0, 32'h50, 32'h0, 4'h0);
        set_dbg(1, 0, 32'h60, 32'h0, 4'h0, 0);
        step("mix1", 0, 1);
        set_dbg(0, 0, 32'h60, 32'h0, 4'h0, 0);
        set_core(1, 0, 32'h70, 32'h0, 4'h0);
        step("mix2", 1, 0);
        set_core(0, 0, 32'h70, 32'h0, 4'h0);
        repeat (5) step("drain", 0, 0);

        set_core(1, 0, 32'h80, 32'h0, 4'h0);
        step("rf", 1, 0);
        rst_n = 1'b0;
        sb.delete();
        step("rf_rst0", 0, 0);
        step("rf_rst1", 0, 0);
        set_core(0, 0, 32'h80, 32'h0, 4'h0);
        rst_n = 1'b1;
        repeat (5) step("rf_idle", 0, 0);

        set_core(1, 0, 32'h90, 32'h0, 4'h0);
        set_dbg(1, 0, 32'hA0, 32'h0, 4'h0, 0);
        step("rcont0", 1, 0);
        step("rcont1", 0, 1);
        set_core(0, 0, 32'h90, 32'h0, 4'h0);
        set_dbg(0, 0, 32'hA0, 32'h0, 4'h0, 0);
        repeat (5) step("drain", 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
